// File: rtl/axi_rd_arb_pkg.sv
// rtl/axi_rd_arb_pkg.sv - shared types and widths for the AXI read-channel arbiter
//
// Purpose: channel payload structs, FSM state type and ID-tagging constants
// used by axi_rd_arbiter and its testbench.
// Widths:  slave-side ID width comes from AXI_IDS_BITS (8 unless the build
//          already defines it); master-side ID width is IDM_W; the master
//          index sits in TAG_BITS bits directly above the master ID.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

package axi_rd_arb_pkg;

  localparam int IDS_BITS    = `AXI_IDS_BITS;
  localparam int IDM_W       = 4;
  localparam int TAG_BITS    = 2;
  localparam int ID_PAD_BITS = IDS_BITS - TAG_BITS - IDM_W;

  typedef struct packed {
    logic [IDM_W-1:0] id;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } ar_m_t;

  typedef struct packed {
    logic [IDS_BITS-1:0] id;
    logic [31:0]         addr;
    logic [3:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } ar_s_t;

  typedef struct packed {
    logic [IDM_W-1:0] id;
    logic [31:0]      data;
    logic [1:0]       resp;
    logic             last;
  } r_m_t;

  typedef struct packed {
    logic [IDS_BITS-1:0] id;
    logic [31:0]         data;
    logic [1:0]          resp;
    logic                last;
  } r_s_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  // Slave-side ID: zero pad, master tag, original master ID.
  function automatic logic [IDS_BITS-1:0] tag_id(input logic [TAG_BITS-1:0] tag,
                                                 input logic [IDM_W-1:0]    id);
    return {{ID_PAD_BITS{1'b0}}, tag, id};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_picker.sv
// rtl/axi_rd_arbiter_rr_picker.sv - rotating-priority request picker
//
// Purpose: choose the first active request at or after ptr, wrapping at NUM_M.
// Ports:
//   req     in   NUM_M  request vector
//   ptr     in   2      index holding highest priority (must be < NUM_M)
//   onehot  out  NUM_M  one-hot winner, all zero when nothing requests
//   idx     out  2      winner index
//   any     out  1      at least one request present

module rr_picker #(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [1:0]       ptr,
  output logic [NUM_M-1:0] onehot,
  output logic [1:0]       idx,
  output logic             any
);

  logic [2:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      // Candidate index ptr+i folded back into 0..NUM_M-1.
      cand = {1'b0, ptr} + 3'(i);
      if (cand >= 3'(NUM_M)) begin
        cand = cand - 3'(NUM_M);
      end
      // Inner scan turns the computed index into a constant bit select.
      for (int j = 0; j < NUM_M; j++) begin
        if (!any && (cand == 3'(j)) && req[j]) begin
          onehot[j] = 1'b1;
          idx       = 2'(j);
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI slave read port between NUM_M read masters
//
// Purpose: grants one read burst at a time. The winning AR is latched and
// forwarded with the master index tagged into the upper ID bits; R beats are
// then routed combinationally to the granted master until RLAST.
// Build option: RD_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, rr_ptr held at 0); left undefined the arbitration is round-robin.
// Ports:
//   ACLK, ARESETn        clock, asynchronous active-low reset
//   M_AR[NUM_M]          in   per-master AR payload
//   M_ARVALID/M_ARREADY  in/out per-master AR handshake
//   M_R[NUM_M]           out  per-master R payload (ID truncated to IDM_BITS)
//   M_RVALID/M_RREADY    out/in per-master R handshake
//   S_AR, S_ARVALID      out  slave AR payload (tagged 8-bit ID) and valid
//   S_ARREADY            in   slave AR ready
//   S_R, S_RVALID        in   slave R payload and valid
//   S_RREADY             out  slave R ready

module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int NUM_M    = 2,
  parameter int IDM_BITS = IDM_W
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  ar_m_t            M_AR      [NUM_M],
  input  logic [NUM_M-1:0] M_ARVALID,
  output logic [NUM_M-1:0] M_ARREADY,
  output r_m_t             M_R       [NUM_M],
  output logic [NUM_M-1:0] M_RVALID,
  input  logic [NUM_M-1:0] M_RREADY,
  output ar_s_t            S_AR,
  output logic             S_ARVALID,
  input  logic             S_ARREADY,
  input  r_s_t             S_R,
  input  logic             S_RVALID,
  output logic             S_RREADY
);

  state_t           state;
  logic [1:0]       grant;
  logic [1:0]       rr_ptr;
  logic [NUM_M-1:0] win_oh;
  logic [1:0]       win_idx;
  logic             win_any;
  ar_m_t            win_ar;
  ar_s_t            win_sar;
  logic             g_rready;
  logic             r_done;

  // Upper slave ID bits carry our own tag back; routing uses grant instead.
  logic [IDS_BITS-IDM_BITS-1:0] unused_rid_tag;
  assign unused_rid_tag = S_R.id[IDS_BITS-1:IDM_BITS];

  // In fixed-priority builds rr_ptr never leaves 0, so the same picker
  // degenerates to lowest-index-wins.
  rr_picker #(
    .NUM_M (NUM_M)
  ) u_picker (
    .req    (M_ARVALID),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_comb begin
    win_ar = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (win_oh[i]) begin
        win_ar = M_AR[i];
      end
    end
    win_sar.id    = tag_id(win_idx, win_ar.id);
    win_sar.addr  = win_ar.addr;
    win_sar.len   = win_ar.len;
    win_sar.size  = win_ar.size;
    win_sar.burst = win_ar.burst;
  end

  always_comb begin
    g_rready = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant == 2'(i)) begin
        g_rready = M_RREADY[i];
      end
    end
  end

  assign r_done = S_RVALID && g_rready && S_R.last;

  // AR ready is offered only while idle; gating with ARESETn keeps it low
  // while reset is held even if a master already drives ARVALID.
  always_comb begin
    M_ARREADY = '0;
    M_RVALID  = '0;
    S_RREADY  = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      M_R[i] = '0;
    end
    if (ARESETn && (state == IDLE)) begin
      M_ARREADY = win_oh;
    end
    if (state == DATA) begin
      S_RREADY = g_rready;
      for (int i = 0; i < NUM_M; i++) begin
        if (grant == 2'(i)) begin
          M_RVALID[i]  = S_RVALID;
          M_R[i].id    = S_R.id[IDM_BITS-1:0];
          M_R[i].data  = S_R.data;
          M_R[i].resp  = S_R.resp;
          M_R[i].last  = S_R.last;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      S_ARVALID <= 1'b0;
      S_AR      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_any) begin
            grant     <= win_idx;
            S_AR      <= win_sar;
            S_ARVALID <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (S_ARREADY) begin
            S_ARVALID <= 1'b0;
            S_AR      <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_done) begin
            state <= IDLE;
`ifdef RD_ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`else
            // The master just served drops to lowest priority.
            rr_ptr <= (grant == 2'(NUM_M - 1)) ? 2'd0 : grant + 2'd1;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          S_ARVALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter

module tb_axi_rd_arbiter;
  import axi_rd_arb_pkg::*;

  localparam int NUM_M = 2;

  logic             ACLK = 1'b0;
  logic             ARESETn;
  ar_m_t            M_AR [NUM_M];
  logic [NUM_M-1:0] M_ARVALID;
  logic [NUM_M-1:0] M_ARREADY;
  r_m_t             M_R [NUM_M];
  logic [NUM_M-1:0] M_RVALID;
  logic [NUM_M-1:0] M_RREADY;
  ar_s_t            S_AR;
  logic             S_ARVALID;
  logic             S_ARREADY;
  r_s_t             S_R;
  logic             S_RVALID;
  logic             S_RREADY;

  always #5 ACLK = ~ACLK;

  axi_rd_arbiter #(.NUM_M(NUM_M), .IDM_BITS(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M_AR(M_AR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_R(M_R), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .S_AR(S_AR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_R(S_R), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_ptr = 0;

  r_s_t tx_beats [$];
  r_m_t obs_beats [$];
  logic [NUM_M-1:0] obs_arready, busy_arready, exp_oh;
  ar_s_t obs_ar;
  logic obs_arvalid, ar_stable, mirror_ok, other_rv, timeout;

  // Reference: first requester scanning upward from the priority pointer.
  function automatic int model_pick(input logic [NUM_M-1:0] req);
    int p, c;
`ifdef RD_ARB_FIXED_PRIO_EN
    p = 0;
`else
    p = exp_ptr;
`endif
    for (int i = 0; i < NUM_M; i++) begin
      c = (p + i) % NUM_M;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  function automatic ar_s_t exp_sar(input ar_m_t a, input int m);
    ar_s_t s;
    s.id    = 8'(m * 16 + int'(a.id));
    s.addr  = a.addr;
    s.len   = a.len;
    s.size  = a.size;
    s.burst = a.burst;
    return s;
  endfunction

  function automatic r_m_t to_m(input r_s_t b);
    r_m_t m;
    m.id   = 4'(b.id % 16);
    m.data = b.data;
    m.resp = b.resp;
    m.last = b.last;
    return m;
  endfunction

  function automatic ar_m_t rand_ar();
    ar_m_t a;
    a.id = 4'($urandom); a.addr = $urandom; a.len = 4'($urandom_range(0, 3));
    a.size = 3'($urandom); a.burst = 2'($urandom);
    return a;
  endfunction

  task automatic make_beats(input int len);
    r_s_t b;
    tx_beats.delete();
    for (int i = 0; i <= len; i++) begin
      b.id = 8'($urandom); b.data = $urandom; b.resp = 2'($urandom);
      b.last = (i == len);
      tx_beats.push_back(b);
    end
  endtask

  // Drives one whole transaction for master w and records what was seen.
  // rmode: 0 ready always, 1 ready toggles 1,0,1,..., 2 random ready.
  task automatic xfer(input int w, input int ar_wait, input int rmode);
    int bi, cyc;
    logic rr;
    busy_arready = '0; other_rv = 1'b0; mirror_ok = 1'b1; ar_stable = 1'b1;
    timeout = 1'b0; obs_beats.delete();
    #1 obs_arready = M_ARREADY;
    @(posedge ACLK); #1;
    M_ARVALID[w] = 1'b0;
    #1 obs_ar = S_AR; obs_arvalid = S_ARVALID; busy_arready |= M_ARREADY;
    for (int k = 0; k < ar_wait; k++) begin
      @(posedge ACLK); #1;
      if (S_ARVALID !== 1'b1 || S_AR !== obs_ar) ar_stable = 1'b0;
      busy_arready |= M_ARREADY;
    end
    S_ARREADY = 1'b1;
    @(posedge ACLK); #1;
    S_ARREADY = 1'b0;
    bi = 0; cyc = 0;
    while (bi < tx_beats.size() && cyc < 200) begin
      S_R = tx_beats[bi]; S_RVALID = 1'b1;
      rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom);
      M_RREADY = NUM_M'($urandom);
      M_RREADY[w] = rr;
      #1;
      if (S_RREADY !== M_RREADY[w] || M_RVALID[w] !== 1'b1) mirror_ok = 1'b0;
      for (int i = 0; i < NUM_M; i++) if (i != w && M_RVALID[i] !== 1'b0) other_rv = 1'b1;
      busy_arready |= M_ARREADY;
      if (M_RVALID[w] && M_RREADY[w]) begin
        obs_beats.push_back(M_R[w]);
        bi++;
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    S_RVALID = 1'b0; M_RREADY = '0;
    if (cyc >= 200) timeout = 1'b1;
    exp_ptr = (w + 1) % NUM_M;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0; M_ARVALID = 2'b01; S_RVALID = 1'b1; M_RREADY = '1;
    repeat (3) @(posedge ACLK);
    #1;
    total_cnt++; if (M_ARREADY !== '0) $display("FAIL rst_arready: got %b want 0", M_ARREADY); else pass_cnt++;
    total_cnt++; if (S_ARVALID !== 1'b0) $display("FAIL rst_s_arvalid: got %b want 0", S_ARVALID); else pass_cnt++;
    total_cnt++; if (S_AR !== '0) $display("FAIL rst_s_ar: got %h want 0", S_AR); else pass_cnt++;
    total_cnt++; if (M_RVALID !== '0) $display("FAIL rst_rvalid: got %b want 0", M_RVALID); else pass_cnt++;
    total_cnt++; if (S_RREADY !== 1'b0) $display("FAIL rst_s_rready: got %b want 0", S_RREADY); else pass_cnt++;
    total_cnt++; if (M_R[0] !== '0 || M_R[1] !== '0) $display("FAIL rst_m_r: got %h %h want 0", M_R[0], M_R[1]); else pass_cnt++;
    M_ARVALID = '0;
    ARESETn = 1'b1;
    #1;
    total_cnt++; if (S_RREADY !== 1'b0) $display("FAIL idle_s_rready: got %b want 0", S_RREADY); else pass_cnt++;
    S_RVALID = 1'b0; M_RREADY = '0;
    @(posedge ACLK); #1;
    total_cnt++; if (S_ARVALID !== 1'b0) $display("FAIL idle_no_req: got %b want 0", S_ARVALID); else pass_cnt++;
    exp_ptr = 0;
  endtask

  task automatic test_single();
    int w;
    M_AR[0] = '{id: 4'h3, addr: 32'h100, len: 4'd0, size: 3'd2, burst: 2'd1};
    M_ARVALID = 2'b01;
    w = model_pick(M_ARVALID);
    exp_oh = '0; exp_oh[w] = 1'b1;
    make_beats(0);
    tx_beats[0].id = 8'h03; tx_beats[0].data = 32'hDEADBEEF; tx_beats[0].resp = 2'd0;
    xfer(w, 0, 0);
    total_cnt++; if (obs_arready !== exp_oh) $display("FAIL single_arready: got %b want %b", obs_arready, exp_oh); else pass_cnt++;
    total_cnt++; if (obs_ar.id !== 8'h03) $display("FAIL single_s_ar_id: got %h want 03", obs_ar.id); else pass_cnt++;
    total_cnt++; if (obs_ar !== exp_sar(M_AR[0], w)) $display("FAIL single_s_ar: got %h want %h", obs_ar, exp_sar(M_AR[0], w)); else pass_cnt++;
    total_cnt++; if (obs_beats.size() != 1) $display("FAIL single_beats: got %0d want 1", obs_beats.size());
    else if (obs_beats[0] !== '{id: 4'h3, data: 32'hDEADBEEF, resp: 2'd0, last: 1'b1})
      $display("FAIL single_beat: got %h want 3/deadbeef/0/1", obs_beats[0]);
    else pass_cnt++;
    total_cnt++; if (other_rv !== 1'b0 || timeout !== 1'b0) $display("FAIL single_route: other_rv %b timeout %b want 0 0", other_rv, timeout); else pass_cnt++;
    #1;
    total_cnt++; if (S_ARVALID !== 1'b0 || M_RVALID !== '0) $display("FAIL single_idle: arvalid %b rvalid %b want 0", S_ARVALID, M_RVALID); else pass_cnt++;
  endtask

  task automatic test_both_same_cycle();
    int w;
    ARESETn = 1'b0; @(posedge ACLK); #1; ARESETn = 1'b1; exp_ptr = 0;
    M_AR[0] = rand_ar(); M_AR[1] = rand_ar(); M_ARVALID = 2'b11;
    for (int r = 0; r < 2; r++) begin
      w = model_pick(M_ARVALID);
      exp_oh = '0; exp_oh[w] = 1'b1;
      make_beats(int'(M_AR[w].len));
      xfer(w, $urandom_range(0, 2), 0);
      total_cnt++; if (obs_arready !== exp_oh) $display("FAIL both_arready_%0d: got %b want %b", r, obs_arready, exp_oh); else pass_cnt++;
      total_cnt++; if (obs_ar !== exp_sar(M_AR[w], w)) $display("FAIL both_s_ar_%0d: got %h want %h", r, obs_ar, exp_sar(M_AR[w], w)); else pass_cnt++;
      total_cnt++; if (busy_arready !== '0) $display("FAIL both_busy_arready_%0d: got %b want 0", r, busy_arready); else pass_cnt++;
      total_cnt++; if (obs_beats.size() != tx_beats.size()) $display("FAIL both_nbeats_%0d: got %0d want %0d", r, obs_beats.size(), tx_beats.size()); else pass_cnt++;
    end
  endtask

  task automatic test_burst_toggle();
    int w;
    M_AR[1] = rand_ar(); M_AR[1].len = 4'd3; M_ARVALID = 2'b10;
    w = model_pick(M_ARVALID);
    make_beats(3);
    xfer(w, 0, 1);
    total_cnt++; if (obs_beats.size() != 4) $display("FAIL toggle_nbeats: got %0d want 4", obs_beats.size()); else pass_cnt++;
    for (int i = 0; i < obs_beats.size() && i < 4; i++) begin
      total_cnt++; if (obs_beats[i] !== to_m(tx_beats[i])) $display("FAIL toggle_beat_%0d: got %h want %h", i, obs_beats[i], to_m(tx_beats[i])); else pass_cnt++;
    end
    total_cnt++; if (mirror_ok !== 1'b1) $display("FAIL toggle_rready_mirror: got %b want 1", mirror_ok); else pass_cnt++;
    total_cnt++; if (other_rv !== 1'b0) $display("FAIL toggle_m0_rvalid: got %b want 0", other_rv); else pass_cnt++;
  endtask

  task automatic test_ar_stall();
    int m, w;
    m = $urandom_range(0, NUM_M - 1);
    M_AR[m] = rand_ar(); M_ARVALID = '0; M_ARVALID[m] = 1'b1;
    w = model_pick(M_ARVALID);
    make_beats(int'(M_AR[w].len));
    xfer(w, 5, 2);
    total_cnt++; if (obs_arvalid !== 1'b1 || ar_stable !== 1'b1) $display("FAIL stall_stable: valid %b stable %b want 1 1", obs_arvalid, ar_stable); else pass_cnt++;
    total_cnt++; if (obs_ar !== exp_sar(M_AR[w], w)) $display("FAIL stall_s_ar: got %h want %h", obs_ar, exp_sar(M_AR[w], w)); else pass_cnt++;
    total_cnt++; if (obs_beats.size() != tx_beats.size() || timeout) $display("FAIL stall_nbeats: got %0d want %0d", obs_beats.size(), tx_beats.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w;
    M_AR[0] = rand_ar(); M_AR[1] = rand_ar(); M_ARVALID = 2'b11;
    for (int r = 0; r < 6; r++) begin
      w = model_pick(M_ARVALID);
      exp_oh = '0; exp_oh[w] = 1'b1;
      make_beats(int'(M_AR[w].len));
      xfer(w, $urandom_range(0, 2), $urandom_range(0, 2));
      total_cnt++; if (obs_arready !== exp_oh) $display("FAIL b2b_grant_%0d: got %b want %b", r, obs_arready, exp_oh); else pass_cnt++;
      total_cnt++; if (obs_ar !== exp_sar(M_AR[w], w)) $display("FAIL b2b_s_ar_%0d: got %h want %h", r, obs_ar, exp_sar(M_AR[w], w)); else pass_cnt++;
      total_cnt++; if (obs_beats.size() != tx_beats.size() || obs_beats[obs_beats.size()-1] !== to_m(tx_beats[tx_beats.size()-1]))
        $display("FAIL b2b_beats_%0d: got %0d beats want %0d", r, obs_beats.size(), tx_beats.size());
      else pass_cnt++;
      M_AR[w] = rand_ar(); M_ARVALID[w] = 1'b1;
    end
    M_ARVALID = '0;
  endtask

  task automatic test_reset_mid_burst();
    int w;
    M_AR[0] = rand_ar(); M_AR[0].len = 4'd3; M_ARVALID = 2'b01;
    @(posedge ACLK); #1;
    M_ARVALID = '0; S_ARREADY = 1'b1;
    @(posedge ACLK); #1;
    S_ARREADY = 1'b0;
    S_R = '{id: 8'($urandom), data: $urandom, resp: 2'd0, last: 1'b0};
    S_RVALID = 1'b1; M_RREADY = 2'b01;
    @(posedge ACLK); #1;
    S_R.data = $urandom;
    #1;
    total_cnt++; if (M_RVALID !== 2'b01) $display("FAIL midrst_pre_rvalid: got %b want 01", M_RVALID); else pass_cnt++;
    ARESETn = 1'b0;
    #1;
    total_cnt++; if (M_RVALID !== '0 || S_RREADY !== 1'b0) $display("FAIL midrst_r: rvalid %b rready %b want 0 0", M_RVALID, S_RREADY); else pass_cnt++;
    total_cnt++; if (S_ARVALID !== 1'b0 || M_ARREADY !== '0 || M_R[0] !== '0) $display("FAIL midrst_ar: arvalid %b arready %b m_r %h want 0", S_ARVALID, M_ARREADY, M_R[0]); else pass_cnt++;
    @(posedge ACLK); #1;
    total_cnt++; if (M_RVALID !== '0 || S_RREADY !== 1'b0) $display("FAIL midrst_next: rvalid %b rready %b want 0 0", M_RVALID, S_RREADY); else pass_cnt++;
    ARESETn = 1'b1; S_RVALID = 1'b0; M_RREADY = '0; exp_ptr = 0;
    @(posedge ACLK); #1;
    M_AR[1] = rand_ar(); M_ARVALID = 2'b10;
    w = model_pick(M_ARVALID);
    exp_oh = '0; exp_oh[w] = 1'b1;
    make_beats(int'(M_AR[w].len));
    xfer(w, 1, 0);
    total_cnt++; if (obs_arready !== exp_oh) $display("FAIL midrst_after_grant: got %b want %b", obs_arready, exp_oh); else pass_cnt++;
    total_cnt++; if (obs_ar !== exp_sar(M_AR[w], w)) $display("FAIL midrst_after_s_ar: got %h want %h", obs_ar, exp_sar(M_AR[w], w)); else pass_cnt++;
    total_cnt++; if (obs_beats.size() != tx_beats.size() || obs_beats[0] !== to_m(tx_beats[0]))
      $display("FAIL midrst_after_beats: got %0d want %0d", obs_beats.size(), tx_beats.size());
    else pass_cnt++;
  endtask

  initial begin
    ARESETn = 1'b0; M_ARVALID = '0; M_RREADY = '0; S_ARREADY = 1'b0;
    S_R = '0; S_RVALID = 1'b0;
    for (int i = 0; i < NUM_M; i++) M_AR[i] = '0;
    test_reset();
    test_single();
    test_both_same_cycle();
    test_burst_toggle();
    test_ar_stall();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Read-channel arbiter that shares one AXI slave read port (the SRAM wrapper) between NUM_M read masters, e.g. instruction fetch and data load.
- Grants exactly one read burst at a time, because the slave serves one outstanding transaction.
- Latches the winning AR request, forwards it with a master tag in the upper ID bits, then routes R beats back to the granted master until RLAST.

Parameters:
- NUM_M, 2, number of read masters (2..4).
- IDM_BITS, 4, master-side ID width; slave-side ID width is fixed at 8 (`AXI_IDS_BITS).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- M_AR  in  [NUM_M] x ar_m_t  per-master AR payload {id, addr[31:0], len[3:0], size[2:0], burst[1:0]}
- M_ARVALID  in  NUM_M  per-master AR valid
- M_ARREADY  out  NUM_M  per-master AR ready
- M_R  out  [NUM_M] x r_m_t  per-master R payload {id, data[31:0], resp[1:0], last}
- M_RVALID  out  NUM_M  per-master R valid
- M_RREADY  in  NUM_M  per-master R ready
- S_AR  out  ar_s_t  slave AR payload (8-bit id)
- S_ARVALID  out  1  slave AR valid
- S_ARREADY  in  1  slave AR ready
- S_R  in  r_s_t  slave R payload (8-bit id)
- S_RVALID  in  1  slave R valid
- S_RREADY  out  1  slave R ready

Behaviour:
- Reset values: state IDLE; M_ARREADY=0, M_RVALID=0, S_ARVALID=0, S_RREADY=0, S_AR=0, M_R=0; rr_ptr=0; grant=0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any M_ARVALID, pick the winner round-robin: first requester at or after rr_ptr.
  - Assert M_ARREADY[win]=1 combinationally that cycle; all other M_ARREADY=0.
  - Latch payload and grant; go to ADDR.
- ADDR:
  - S_ARVALID=1; S_AR = latched payload with id = {zero pad, grant[1:0], id[3:0]}.
  - Held stable until S_ARREADY; on handshake go to DATA.
- DATA:
  - M_RVALID[grant]=S_RVALID; S_RREADY=M_RREADY[grant]; M_R[grant] = S_R with id truncated to low IDM_BITS.
  - All non-granted M_RVALID=0.
  - On S_RVALID & S_RREADY & S_R.last: go to IDLE, rr_ptr = grant+1 mod NUM_M.
- Latency: minimum 1 cycle from M_ARVALID to S_ARVALID. Burst of L+1 beats passes R with zero added latency (pure routing).
- M_ARREADY=0 in ADDR and DATA; new requests wait, and ARVALID must stay asserted per AXI.
- Simultaneous requests: rr_ptr decides; a second request from the same master after its burst loses to any other pending master.
- S_RVALID outside DATA: S_RREADY stays 0; data not consumed.
- R routing uses the registered grant only; the tag bits of S_R.id are not checked.
- Reset mid-burst: immediate return to IDLE, all valids/readys 0; any partially returned burst is abandoned.

Optional Feature:
- Macro RD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins in IDLE; rr_ptr is unused and held at 0.
- Undefined: round-robin as above.

Decomposition:
- Package axi_rd_arb_pkg holds:
  - ar_m_t, ar_s_t, r_m_t, r_s_t packed structs;
  - state_t enum;
  - TAG_BITS=2 and ID pad constants, reusing AXI_define.svh widths.
- One sub-module rr_picker (NUM_M request vector + pointer -> one-hot winner, index, any).

Test Plan:
- Single read, M0 only: id 4'h3, addr 0x100, len 0 -> S_AR.id 8'h03; one R beat data 0xDEADBEEF delivered to M0 with id 4'h3, last=1; return to IDLE.
- Both masters valid in the same cycle after reset -> M0 granted first (S_AR.id 8'h0x), then M1 (S_AR.id 8'h1x); M1 ARREADY stays 0 until M0 RLAST.
- Burst len 3 to M1 with M1 RREADY toggling 1,0,1,0... -> 4 beats in order, S_RREADY mirrors M1 RREADY, M0 RVALID stays 0 throughout.
- S_ARREADY held 0 for 5 cycles in ADDR -> S_ARVALID and S_AR stable all 5 cycles; handshake on cycle 6.
- Repeated requests from both masters -> grants alternate M0, M1, M0, M1; with RD_ARB_FIXED_PRIO_EN, M0 wins every round.
- ARESETn low during beat 2 of a 4-beat burst -> next cycle all outputs 0, state IDLE; new request after release served normally.
